// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared 32-bit ALU: latches the winning request, holds the ALU
// inputs for the op latency, then strobes the captured result back. Optional macro: ALU_ARB_FIXED_PRIO_EN.
module alu_share_arbiter #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic [2:0]  req0_ctrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  input  logic [2:0]  req1_ctrl_i,
  output logic        rsp0_valid_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_zero_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] LP_MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [2:0] LP_OP_MUL  = 3'b010;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [2:0]  r_ctrl;
  logic        r_owner;
  logic [3:0]  r_cnt;
  logic [31:0] r_rsp_data;
  logic        r_rsp_zero;
  logic        w_accept;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_hs;
  logic [31:0] w_sel_d1;
  logic [31:0] w_sel_d2;
  logic [2:0]  w_sel_ctrl;

  assign w_accept = (r_state != S_EXEC);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_grant0 = w_accept & req0_valid_i;
  assign w_grant1 = w_accept & req1_valid_i & ~req0_valid_i;
`else
  logic r_last_grant;
  // On contention the port that did not win last time gets the grant.
  assign w_grant0 = w_accept & req0_valid_i & (~req1_valid_i | r_last_grant);
  assign w_grant1 = w_accept & req1_valid_i & (~req0_valid_i | ~r_last_grant);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= 1'b1;
    end else if (w_hs) begin
      r_last_grant <= w_grant1;
    end
  end
`endif

  assign w_hs       = w_grant0 | w_grant1;
  assign w_sel_d1   = w_grant1 ? req1_data1_i : req0_data1_i;
  assign w_sel_d2   = w_grant1 ? req1_data2_i : req0_data2_i;
  assign w_sel_ctrl = w_grant1 ? req1_ctrl_i  : req0_ctrl_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req0_ready_o = w_grant0;
    req1_ready_o = w_grant1;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    busy_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) w_state_next = S_EXEC;
      end
      S_EXEC: begin
        busy_o = 1'b1;
        if (r_cnt == 4'd1) w_state_next = S_RESP;
      end
      S_RESP: begin
        rsp0_valid_o = ~r_owner;
        rsp1_valid_o = r_owner;
        w_state_next = w_hs ? S_EXEC : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Accept and execute are mutually exclusive, so EXEC takes priority without losing a handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_ctrl     <= '0;
      r_owner    <= 1'b0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_rsp_data <= alu_data_i;
        r_rsp_zero <= alu_zero_i;
      end
    end else if (w_hs) begin
      r_op1   <= w_sel_d1;
      r_op2   <= w_sel_d2;
      r_ctrl  <= w_sel_ctrl;
      r_owner <= w_grant1;
      r_cnt   <= (w_sel_ctrl == LP_OP_MUL) ? LP_MUL_CNT : 4'd1;
    end
  end

  assign alu_data1_o = r_op1;
  assign alu_data2_o = r_op2;
  assign alu_ctrl_o  = r_ctrl;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_zero_o  = r_rsp_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised scoreboard bench for alu_share_arbiter with a behavioural ALU and arbitration model.
module tb_alu_share_arbiter;
  localparam int MULC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, r0, r1, rsp0, rsp1, rzero, busy, alu_z;
  logic [31:0] a0, b0, a1, b1, rdata, alu_d1, alu_d2, alu_res;
  logic [2:0]  c0, c1, alu_c;

  always #5 clk = ~clk;

  alu_share_arbiter #(.MUL_CYCLES(MULC)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_data1_i(a0), .req0_data2_i(b0), .req0_ctrl_i(c0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_data1_i(a1), .req1_data2_i(b1), .req1_ctrl_i(c1),
    .rsp0_valid_o(rsp0), .rsp1_valid_o(rsp1), .rsp_data_o(rdata), .rsp_zero_o(rzero),
    .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .alu_ctrl_o(alu_c),
    .alu_data_i(alu_res), .alu_zero_i(alu_z), .busy_o(busy)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      default: return (a ^ b) + {29'd0, c};
    endcase
  endfunction

  always_comb begin
    alu_res = alu_f(alu_d1, alu_d2, alu_c);
    alu_z   = (alu_res == 32'd0);
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          zero;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: accept window, arbitration, held operands and response timing.
  bit          m_last = 1'b1;
  int          m_free = 0;
  logic [31:0] m_op1  = '0;
  logic [31:0] m_op2  = '0;
  logic [2:0]  m_ctrl = '0;

  always @(negedge clk) begin : predictor
    bit          open, e0, e1;
    logic [31:0] pa, pb, res;
    logic [2:0]  pc;
    int          lat;
    if (rst) begin
      m_last = 1'b1; m_free = 0; m_op1 = '0; m_op2 = '0; m_ctrl = '0;
      sb.delete();
    end else begin
      open = (cyc >= m_free);
`ifdef ALU_ARB_FIXED_PRIO_EN
      e0 = open && v0;
      e1 = open && v1 && !v0;
`else
      e0 = open && v0 && (!v1 || m_last);
      e1 = open && v1 && (!v0 || !m_last);
`endif
      chk("ready0", {63'd0, r0}, {63'd0, e0});
      chk("ready1", {63'd0, r1}, {63'd0, e1});
      chk("busy", {63'd0, busy}, {63'd0, cyc < m_free});
      chk("alu_hold", {alu_c, alu_d1, alu_d2}, {m_ctrl, m_op1, m_op2});
      if (e0 || e1) begin
        pa  = e1 ? a1 : a0;
        pb  = e1 ? b1 : b0;
        pc  = e1 ? c1 : c0;
        lat = (pc == 3'd2) ? MULC : 1;
        res = alu_f(pa, pb, pc);
        m_free = cyc + 1 + lat;
        m_last = e1;
        m_op1 = pa; m_op2 = pb; m_ctrl = pc;
        sb.push_back('{port: e1, data: res, zero: (res == 32'd0), cyc: cyc + 1 + lat});
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("rsp_missing_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (rsp0 && rsp1) begin
        chk("rsp_both", 2'b11, 2'b00);
      end else if (rsp0 || rsp1) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {rsp1, rsp0}, 2'b00);
        end else begin
          e = sb.pop_front();
          $display("rsp port=%0d data=%h zero=%0d cyc=%0d", rsp1, rdata, rzero, cyc);
          chk("rsp_port", {63'd0, rsp1}, {63'd0, e.port});
          chk("rsp_data", rdata, e.data);
          chk("rsp_zero", {63'd0, rzero}, {63'd0, e.zero});
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    bit hs = 1'b0;
    @(posedge clk); #1;
    if (p) begin v1 = 1'b1; a1 = a; b1 = b; c1 = c; end
    else   begin v0 = 1'b1; a0 = a; b0 = b; c0 = c; end
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      hs = p ? r1 : r0;
      @(posedge clk); #1;
    end
    v0 = 1'b0; v1 = 1'b0;
    if (!hs) chk("grant_timeout", 0, 1);
    wait_idle();
  endtask

  task automatic new_op(input bit add_only, output logic [31:0] a, output logic [31:0] b, output logic [2:0] c);
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    c = add_only ? 3'd0 : 3'($urandom_range(0, 7));
  endtask

  task automatic run_random(input int n, input bit keep_valid, input bit add_only);
    bit h0, h1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h0 = v0 && r0;
      h1 = v1 && r1;
      @(posedge clk); #1;
      if (h0 || !v0) begin
        v0 = keep_valid || ($urandom_range(0, 1) == 1);
        new_op(add_only, a0, b0, c0);
      end else if (!keep_valid && $urandom_range(0, 7) == 0) begin
        v0 = 1'b0;
      end
      if (h1 || !v1) begin
        v1 = keep_valid || ($urandom_range(0, 1) == 1);
        new_op(add_only, a1, b1, c1);
      end else if (!keep_valid && $urandom_range(0, 7) == 0) begin
        v1 = 1'b0;
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu", {alu_c, alu_d1, alu_d2}, '0);
    chk("rst_rsp", {rsp0, rsp1, rzero, rdata}, '0);
    chk("rst_busy_ready", {busy, r0, r1}, '0);
    rst = 1'b0;

    issue(0, 32'd5, 32'd7, 3'd0);
    issue(1, 32'd9, 32'd9, 3'd1);
    issue(1, 32'd0, 32'd1, 3'd1);
    issue(0, 32'd3, 32'd4, 3'd2);
    issue(0, 32'h1234, 32'h00FF, 3'd7);
    issue(1, 32'hF0F0, 32'h0F0F, 3'd4);
    issue(0, 32'hFFFF_FFFF, 32'h8000_0001, 3'd3);
    issue(1, 32'h0001_0000, 32'h0001_0000, 3'd2);

    // Port 1 raises and withdraws a request while port 0's multiply executes.
    @(posedge clk); #1;
    v0 = 1'b1; a0 = 32'd6; b0 = 32'd7; c0 = 3'd2;
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b1; a1 = 32'd1; b1 = 32'd1; c1 = 3'd0;
    @(posedge clk); #1;
    v1 = 1'b0;
    wait_idle();

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    v0 = 1'b1; a0 = 32'd11; b0 = 32'd13; c0 = 3'd2;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_alu", {alu_c, alu_d1, alu_d2}, '0);
    chk("midrst_rsp", {rsp0, rsp1, rzero, rdata}, '0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    a0 = 32'd1; b0 = 32'd2; c0 = 3'd0; a1 = 32'd3; b1 = 32'd4; c1 = 3'd0;
    @(negedge clk);
    chk("post_rst_winner", {r1, r0}, 2'b01);

    run_random(40, 1'b1, 1'b1);
    run_random(60, 1'b1, 1'b0);
    run_random(600, 1'b0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
